// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// State and grant encodings plus default widths.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_t;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

endpackage

// File: rtl/unified_mem_arbiter_starve_cnt.sv
// Saturating count of DM grants taken while IF is waiting.
// at_limit tells the arbiter to hand the next slot to IF.
module unified_mem_arbiter_starve_cnt
    import unified_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != LIM) begin
            count <= count + STARVE_W'(1);
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory shared by IF and MEM, MEM first.
// Registers the memory handshake, captures read data, drives stalls.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_inst,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wmask,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t state;
    state_t state_nx;
    grant_t grant;

    logic if_valid_q;
    logic dm_valid_q;
    logic drop_q;
    logic drop_now;
    logic any_valid;
    logic at_limit;
    logic cnt_inc;
    logic cnt_clr;
    logic acked;

    // A completion cycle is a turnaround: the requester still shows the
    // finished access on its req, so nobody is granted until it moves on.
    assign any_valid = if_valid_q | dm_valid_q;
    assign acked     = mem_req & mem_ack;
    assign drop_now  = drop_q | if_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (grant == GNT_DM) begin
                    state_nx = ST_DM_BUSY;
                end else if (grant == GNT_IF) begin
                    state_nx = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY,
            ST_DM_BUSY: begin
                if (acked) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        grant = GNT_NONE;
        if (state == ST_IDLE && !any_valid) begin
            if (dm_req && !(at_limit && if_req)) begin
                grant = GNT_DM;
            end else if (if_req && !if_flush) begin
                grant = GNT_IF;
            end
        end
    end

    assign cnt_inc = (grant == GNT_DM) & if_req;
    assign cnt_clr = (grant == GNT_IF) | ~if_req;

    unified_mem_arbiter_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_inst    <= '0;
            dm_rdata   <= '0;
            drop_q     <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (grant == GNT_DM) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_wmask <= dm_wmask;
            end else if (grant == GNT_IF) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end
            if (acked) begin
                mem_req <= 1'b0;
                if (state == ST_IF_BUSY) begin
                    if (!drop_now) begin
                        if_inst    <= mem_rdata;
                        if_valid_q <= 1'b1;
                    end
                end else begin
                    dm_valid_q <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end
            end
            // A redirect during a fetch poisons its eventual response.
            if (acked && state == ST_IF_BUSY) begin
                drop_q <= 1'b0;
            end else if (state == ST_IF_BUSY && if_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign if_valid = if_valid_q & ~if_flush;
    assign dm_valid = dm_valid_q;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

endmodule
